// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port general-purpose register file.
//
// Two write ports (port 1 wins on an address collision), NREAD
// combinational read ports with optional write-to-read bypass, and an
// optional hardwired zero register at entry 0.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset; also forces all reads to 0
//   i_we0/1        write enables (port 1 has priority)
//   i_waddr0/1     write addresses
//   i_wdata0/1     write data
//   i_re           per-port read enable, bit i -> read port i
//   i_raddr        packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   o_rdata        packed read data, port i at [i*DATA_W +: DATA_W]
//   o_wr_conflict  high for one cycle after a same-address dual write
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we0,
    input  logic [ADDR_W-1:0]       i_waddr0,
    input  logic [DATA_W-1:0]       i_wdata0,
    input  logic                    i_we1,
    input  logic [ADDR_W-1:0]       i_waddr1,
    input  logic [DATA_W-1:0]       i_wdata1,
    input  logic [NREAD-1:0]        i_re,
    input  logic [NREAD*ADDR_W-1:0] i_raddr,
    output logic [NREAD*DATA_W-1:0] o_rdata,
    output logic                    o_wr_conflict
);

    localparam int DEPTH     = 2 ** ADDR_W;
    localparam bit LP_ZERO   = (ZERO_REG != 0);
    localparam bit LP_BYPASS = (BYPASS != 0);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_conflict;
    logic              w_wen0;
    logic              w_wen1;

    // Writes to the hardwired zero entry are dropped before they reach
    // storage, so they also can never raise a conflict.
    assign w_wen0 = i_we0 && !(LP_ZERO && (i_waddr0 == '0));
    assign w_wen1 = i_we1 && !(LP_ZERO && (i_waddr1 == '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_wen0) begin
                r_mem[i_waddr0] <= i_wdata0;
            end
            // Port 1 is assigned last so it overrides port 0 on a collision.
            if (w_wen1) begin
                r_mem[i_waddr1] <= i_wdata1;
            end
            r_wr_conflict <= w_wen0 && w_wen1 && (i_waddr0 == i_waddr1);
        end
    end

    assign o_wr_conflict = r_wr_conflict;

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;

        assign w_raddr = i_raddr[g*ADDR_W +: ADDR_W];

        // Priority: reset, enable, zero register, bypass port 1, bypass
        // port 0, stored value.
        always_comb begin
            w_rdata = r_mem[w_raddr];
            if (i_rst || !i_re[g]) begin
                w_rdata = '0;
            end else if (LP_ZERO && (w_raddr == '0)) begin
                w_rdata = '0;
            end else if (LP_BYPASS && i_we1 && (i_waddr1 == w_raddr)) begin
                w_rdata = i_wdata1;
            end else if (LP_BYPASS && i_we0 && (i_waddr0 == w_raddr)) begin
                w_rdata = i_wdata0;
            end
        end

        assign o_rdata[g*DATA_W +: DATA_W] = w_rdata;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic         we0, we1;
    logic [4:0]   wa0, wa1;
    logic [31:0]  wd0, wd1;
    logic [3:0]   re4;
    logic [19:0]  ra4;

    logic [63:0]  rd0, rd1, rd2;
    logic [127:0] rd3;
    logic         cf0, cf1, cf2, cf3;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: one image honouring the zero register, one without.
    logic [31:0] m_z  [32];
    logic [31:0] m_nz [32];
    logic        c_z, c_nz;

    typedef struct {
        logic        rst;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ec;
    } vec_t;

    vec_t vt [16];

    always #5 clk = ~clk;

    // d0: defaults; d1: no bypass; d2: no zero register; d3: four read ports
    regfile_mp u_d0 (
        .i_clk(clk), .i_rst(rst),
        .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
        .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1),
        .i_re(re4[1:0]), .i_raddr(ra4[9:0]),
        .o_rdata(rd0), .o_wr_conflict(cf0)
    );
    regfile_mp #(.BYPASS(0)) u_d1 (
        .i_clk(clk), .i_rst(rst),
        .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
        .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1),
        .i_re(re4[1:0]), .i_raddr(ra4[9:0]),
        .o_rdata(rd1), .o_wr_conflict(cf1)
    );
    regfile_mp #(.ZERO_REG(0)) u_d2 (
        .i_clk(clk), .i_rst(rst),
        .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
        .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1),
        .i_re(re4[1:0]), .i_raddr(ra4[9:0]),
        .o_rdata(rd2), .o_wr_conflict(cf2)
    );
    regfile_mp #(.NREAD(4)) u_d3 (
        .i_clk(clk), .i_rst(rst),
        .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
        .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1),
        .i_re(re4), .i_raddr(ra4),
        .o_rdata(rd3), .o_wr_conflict(cf3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int r, int e0w, int a0, int d0, int e1w, int a1, int d1,
                                int re, int ra0, int ra1, int x0, int x1, int xc);
        vec_t v;
        v.rst = 1'(r);   v.we0 = 1'(e0w); v.wa0 = 5'(a0); v.wd0 = 32'(d0);
        v.we1 = 1'(e1w); v.wa1 = 5'(a1);  v.wd1 = 32'(d1);
        v.re  = 4'(re);  v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.e0  = 32'(x0); v.e1  = 32'(x1); v.ec  = 1'(xc);
        return v;
    endfunction

    // Expected read value straight from the read rules, in priority order.
    function automatic logic [31:0] exp_rd(bit z, bit b, logic en, logic [4:0] a);
        if (rst)                         return 32'h0;
        if (!en)                         return 32'h0;
        if (z && a == 5'd0)              return 32'h0;
        if (b && we1 && wa1 == a)        return wd1;
        if (b && we0 && wa0 == a)        return wd0;
        return z ? m_z[a] : m_nz[a];
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_z[i]  = 32'h0;
                m_nz[i] = 32'h0;
            end
            c_z  = 1'b0;
            c_nz = 1'b0;
        end else begin
            c_nz = we0 && we1 && (wa0 == wa1);
            c_z  = c_nz && (wa0 != 5'd0);
            if (we0) begin
                m_nz[wa0] = wd0;
                if (wa0 != 5'd0) m_z[wa0] = wd0;
            end
            if (we1) begin
                m_nz[wa1] = wd1;
                if (wa1 != 5'd0) m_z[wa1] = wd1;
            end
        end
    endtask

    task automatic check_reads();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("d0_rd_p%0d", p), rd0[p*32 +: 32], exp_rd(1'b1, 1'b1, re4[p], ra4[p*5 +: 5]));
            chk($sformatf("d1_rd_p%0d", p), rd1[p*32 +: 32], exp_rd(1'b1, 1'b0, re4[p], ra4[p*5 +: 5]));
            chk($sformatf("d2_rd_p%0d", p), rd2[p*32 +: 32], exp_rd(1'b0, 1'b1, re4[p], ra4[p*5 +: 5]));
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("d3_rd_p%0d", p), rd3[p*32 +: 32], exp_rd(1'b1, 1'b1, re4[p], ra4[p*5 +: 5]));
        end
    endtask

    task automatic check_conf();
        chk("d0_conflict", 32'(cf0), 32'(c_z));
        chk("d1_conflict", 32'(cf1), 32'(c_z));
        chk("d2_conflict", 32'(cf2), 32'(c_nz));
        chk("d3_conflict", 32'(cf3), 32'(c_z));
    endtask

    // Entered just after a falling edge with inputs already applied.
    task automatic do_cycle();
        #2;
        check_reads();
        @(posedge clk);
        model_update();
        #1;
        check_conf();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_z[i]  = 32'h0;
            m_nz[i] = 32'h0;
        end
        c_z = 1'b0;
        c_nz = 1'b0;

        // Reset with every read port enabled: all read data must be zero.
        rst = 1'b1; we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h5A5A_5A5A;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hA5A5_A5A5;
        re4 = 4'hF; ra4 = {5'd2, 5'd1, 5'd2, 5'd1};
        do_cycle();
        do_cycle();

        vt[0]  = mk(0, 1, 3, 'hAA,        0, 0, 0,            'hF, 3, 3, 'hAA,        'hAA,        0);
        vt[1]  = mk(1, 1, 4, 'h55,        0, 0, 0,            'hF, 3, 3, 0,           0,           0);
        vt[2]  = mk(0, 0, 0, 0,           0, 0, 0,            'hF, 3, 4, 0,           0,           0);
        vt[3]  = mk(0, 1, 5, 'h1111_1111, 1, 6, 'h2222_2222,  'h0, 5, 6, 0,           0,           0);
        vt[4]  = mk(0, 0, 0, 0,           0, 0, 0,            'hF, 5, 6, 'h1111_1111, 'h2222_2222, 0);
        vt[5]  = mk(0, 1, 7, 'hDEAD_0000, 1, 7, 'hBEEF_0000,  'hF, 7, 7, 'hBEEF_0000, 'hBEEF_0000, 1);
        vt[6]  = mk(0, 0, 0, 0,           0, 0, 0,            'hF, 7, 5, 'hBEEF_0000, 'h1111_1111, 0);
        vt[7]  = mk(0, 1, 9, 'h1234,      0, 0, 0,            'h5, 9, 9, 'h1234,      0,           0);
        vt[8]  = mk(0, 0, 0, 0,           0, 0, 0,            'hF, 9, 0, 'h1234,      0,           0);
        vt[9]  = mk(0, 1, 0, 'hFFFF_FFFF, 1, 0, 'hFFFF_FFFF,  'hF, 0, 0, 0,           0,           0);
        vt[10] = mk(0, 0, 0, 0,           0, 0, 0,            'hF, 0, 0, 0,           0,           0);
        vt[11] = mk(0, 0, 0, 0,           1, 2, 'h42,         'h0, 2, 2, 0,           0,           0);
        vt[12] = mk(0, 0, 0, 0,           0, 0, 0,            'hA, 2, 2, 0,           'h42,        0);
        vt[13] = mk(0, 1, 8, 'hA,         1, 8, 'hB,          'hF, 8, 8, 'hB,         'hB,         1);
        vt[14] = mk(1, 1, 10, 'hC,        1, 10, 'hD,         'hF, 8, 8, 0,           0,           0);
        vt[15] = mk(0, 0, 0, 0,           0, 0, 0,            'hF, 8, 6, 0,           0,           0);

        for (int k = 0; k < 16; k++) begin
            rst = vt[k].rst;
            we0 = vt[k].we0; wa0 = vt[k].wa0; wd0 = vt[k].wd0;
            we1 = vt[k].we1; wa1 = vt[k].wa1; wd1 = vt[k].wd1;
            re4 = vt[k].re;
            ra4 = {vt[k].ra1, vt[k].ra0, vt[k].ra1, vt[k].ra0};
            #2;
            chk($sformatf("vec%0d_p0", k), rd0[31:0], vt[k].e0);
            chk($sformatf("vec%0d_p1", k), rd0[63:32], vt[k].e1);
            check_reads();
            @(posedge clk);
            model_update();
            #1;
            chk($sformatf("vec%0d_conflict", k), 32'(cf0), 32'(vt[k].ec));
            check_conf();
            @(negedge clk);
        end

        // Conflict lasts exactly one cycle, then clears with idle inputs.
        rst = 1'b0; we0 = 1'b1; we1 = 1'b1; wa0 = 5'd12; wa1 = 5'd12;
        wd0 = 32'h0000_0001; wd1 = 32'h0000_0002; re4 = 4'h0;
        do_cycle();
        we0 = 1'b0; we1 = 1'b0; re4 = 4'hF; ra4 = {4{5'd12}};
        #2;
        chk("seq_conflict_hold", 32'(cf0), 32'h1);
        chk("seq_conflict_data", rd0[31:0], 32'h0000_0002);
        @(posedge clk);
        model_update();
        #1;
        chk("seq_conflict_clear", 32'(cf0), 32'h0);
        @(negedge clk);

        // Randomised traffic on a narrow address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 31) == 0);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = 5'($urandom_range(0, 7));
            wa1 = 5'($urandom_range(0, 7));
            wd0 = $urandom;
            wd1 = $urandom;
            re4 = 4'($urandom_range(0, 15));
            for (int p = 0; p < 4; p++) begin
                ra4[p*5 +: 5] = 5'($urandom_range(0, 7));
            end
            do_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the candy core. It is the successor to the fixed 2-read/1-write regfile. It adds:
- configurable data width, depth and read-port count
- a second write port, so a second writeback source (e.g. load/mem stage) can retire in the same cycle as the ALU stage
- write-to-read bypass
- an optional hardwired zero register

It sits between decode (read ports) and writeback (write ports).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary
BYPASS, 1, 1 = read returns same-cycle write data on address match; 0 = read returns stored value

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
re  in  NREAD  per-port read enable; bit i drives read port i
raddr  in  NREAD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
wr_conflict  out  1  registered flag: set for one cycle after a same-address dual write

Behaviour:
- Storage: 2**ADDR_W entries of DATA_W bits.

Reset:
- On a rising edge with rst=1: all entries are cleared to 0 and wr_conflict is cleared to 0. Writes in that cycle are discarded.
- While rst=1, every rdata slice is 0. This is combinational on rst and independent of re and raddr.
- A reset asserted mid-stream takes effect at the next edge. Nothing written in the reset cycle survives.

Write (rst=0, rising edge):
- weN=1 writes wdataN into entry waddrN.
- Both ports enabled with different addresses: both entries are written in the same cycle.
- Both ports enabled with the same address: wdata1 wins, and wr_conflict=1 on the following cycle.
- If ZERO_REG=1, any write to address 0 is ignored. A same-address write to address 0 does not set wr_conflict.
- wr_conflict is 0 in every cycle not preceded by a conflict.

Read (combinational, 0-cycle latency), evaluated per port i:
1. rst=1 -> 0
2. re[i]=0 -> 0
3. ZERO_REG=1 and raddr_i=0 -> 0
4. BYPASS=1, we1=1 and waddr1=raddr_i -> wdata1
5. BYPASS=1, we0=1 and waddr0=raddr_i -> wdata0
6. otherwise -> stored entry
- Priority is strictly in the order listed. Port 1 has precedence over port 0 in the bypass, matching write priority.
- With BYPASS=0, a read of an address being written in the same cycle returns the old value. The new value is visible from the next cycle.
- All read ports are independent. Any number of ports may read the same address.

Arithmetic and width:
- No arithmetic. All address compares are full ADDR_W wide.
- Out-of-range addresses do not exist (depth is an exact power of two).

Test Plan:
- Reset clear: write 0x0000_00AA to r3, assert rst for 1 cycle, read r3 with re=1 -> rdata=0. During the rst cycle all rdata=0 even with re=all-ones.
- Dual write, distinct addresses: we0 r5=0x1111_1111 and we1 r6=0x2222_2222 in one cycle. Next cycle read port0=r5, port1=r6 -> 0x1111_1111 and 0x2222_2222; wr_conflict=0.
- Same-address conflict: we0 and we1 both to r7, with 0xDEAD_0000 and 0xBEEF_0000 -> next cycle r7 reads 0xBEEF_0000 and wr_conflict=1. One cycle later wr_conflict=0.
- Bypass: same cycle we0 r9=0x0000_1234 and read r9 -> rdata=0x0000_1234 when BYPASS=1. Rerun with BYPASS=0 -> old value (0 after reset); next cycle 0x0000_1234.
- Zero register: ZERO_REG=1, write r0=0xFFFF_FFFF on both ports -> r0 reads 0 that cycle and after; wr_conflict=0. With ZERO_REG=0 the same stimulus -> r0 reads 0xFFFF_FFFF next cycle.
- Read enable and multi-port: NREAD=4, all ports read r2 (=0x0000_0042) with re=4'b1010 -> ports 1 and 3 give 0x0000_0042, ports 0 and 2 give 0.
